// File: rtl/fetch_if.sv
// Fetch-stage bus: instruction-memory port, decode/execute control inputs and the IF/ID register outputs.
interface fetch_if;
    logic [31:0] imem_addr;
    logic [31:0] imem_instr;
    logic        stall;
    logic        flush;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        if_id_valid;
    logic [31:0] if_id_pc;
    logic [31:0] if_id_pc_plus4;
    logic [31:0] if_id_instr;
    logic        redirect_misaligned;
    logic [31:0] fetch_count;

    modport master (
        output imem_addr, if_id_valid, if_id_pc, if_id_pc_plus4, if_id_instr,
               redirect_misaligned, fetch_count,
        input  imem_instr, stall, flush, redirect_valid, redirect_pc
    );

    modport slave (
        input  imem_addr, if_id_valid, if_id_pc, if_id_pc_plus4, if_id_instr,
               redirect_misaligned, fetch_count,
        output imem_instr, stall, flush, redirect_valid, redirect_pc
    );
endinterface

// File: rtl/fetch_stage.sv
// RV32 instruction-fetch stage: owns the PC, reads the combinational instruction memory and
// loads the IF/ID register, with redirect > flush > stall > advance priority.
module fetch_stage #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic   clk,
    input  logic   rst,
    fetch_if.master bus
);
    logic [31:0] pc_q, pc_d;
    logic        vld_q, vld_d;
    logic [31:0] id_pc_q, id_pc_d;
    logic [31:0] id_pc4_q, id_pc4_d;
    logic [31:0] id_instr_q, id_instr_d;
    logic        misal_q, misal_d;
    logic [31:0] cnt_q, cnt_d;

    always_comb begin
        pc_d       = pc_q;
        vld_d      = vld_q;
        id_pc_d    = id_pc_q;
        id_pc4_d   = id_pc4_q;
        id_instr_d = id_instr_q;
        misal_d    = 1'b0;
        cnt_d      = cnt_q;
        if (bus.redirect_valid) begin
            // The target is forced word-aligned; the dropped low bits are only reported.
            pc_d       = {bus.redirect_pc[31:2], 2'b00};
            vld_d      = 1'b0;
            id_instr_d = NOP_INSTR;
            misal_d    = |bus.redirect_pc[1:0];
        end else if (bus.flush) begin
            vld_d      = 1'b0;
            id_instr_d = NOP_INSTR;
        end else if (!bus.stall) begin
            vld_d      = 1'b1;
            id_pc_d    = pc_q;
            id_pc4_d   = pc_q + 32'd4;
            id_instr_d = bus.imem_instr;
            pc_d       = pc_q + 32'd4;
            cnt_d      = cnt_q + 32'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q       <= RESET_PC;
            vld_q      <= 1'b0;
            id_pc_q    <= 32'd0;
            id_pc4_q   <= 32'd0;
            id_instr_q <= NOP_INSTR;
            misal_q    <= 1'b0;
            cnt_q      <= 32'd0;
        end else begin
            pc_q       <= pc_d;
            vld_q      <= vld_d;
            id_pc_q    <= id_pc_d;
            id_pc4_q   <= id_pc4_d;
            id_instr_q <= id_instr_d;
            misal_q    <= misal_d;
            cnt_q      <= cnt_d;
        end
    end

    assign bus.imem_addr           = pc_q;
    assign bus.if_id_valid         = vld_q;
    assign bus.if_id_pc            = id_pc_q;
    assign bus.if_id_pc_plus4      = id_pc4_q;
    assign bus.if_id_instr         = id_instr_q;
    assign bus.redirect_misaligned = misal_q;
    assign bus.fetch_count         = cnt_q;
endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: scoreboard of per-cycle expected outputs from a reference model,
// directed test-plan scenarios followed by randomized control traffic.
module tb_fetch_stage;
    localparam logic [31:0] NOP = 32'h0000_0013;

    logic clk = 1'b0;
    logic rst;
    fetch_if bus();
    logic [31:0] mem [64];

    always #5 clk = ~clk;
    assign bus.imem_instr = mem[bus.imem_addr[7:2]];

    fetch_stage dut (.clk(clk), .rst(rst), .bus(bus));

    typedef struct {
        logic [31:0] addr;
        logic        vld;
        logic [31:0] ipc;
        logic [31:0] ipc4;
        logic [31:0] instr;
        logic        mis;
        logic [31:0] cnt;
    } exp_t;

    exp_t m;      // architectural state of the reference model
    exp_t q[$];
    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_tests++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %h, required %h at %0t", name, act, req, $time);
        end
    endtask

    // Reference model: apply one clock edge of the stage's rules with the given controls.
    task automatic model_edge(input logic r, input logic rv, input logic [31:0] rp,
                              input logic fl, input logic st);
        logic [31:0] fetched;
        fetched = mem[m.addr[7:2]];
        m.mis = 1'b0;
        if (r) begin
            m = '{addr: 32'h0, vld: 1'b0, ipc: 32'h0, ipc4: 32'h0, instr: NOP, mis: 1'b0, cnt: 32'h0};
        end else if (rv) begin
            m.addr  = rp & 32'hFFFF_FFFC;
            m.vld   = 1'b0;
            m.instr = NOP;
            m.mis   = (rp % 4) != 0;
        end else if (fl) begin
            m.vld   = 1'b0;
            m.instr = NOP;
        end else if (!st) begin
            m.vld   = 1'b1;
            m.ipc   = m.addr;
            m.ipc4  = m.addr + 4;
            m.instr = fetched;
            m.addr  = m.addr + 4;
            m.cnt   = m.cnt + 1;
        end
    endtask

    // Drive one cycle of controls and queue the outputs expected after the coming edge.
    task automatic cyc(input logic r, input logic rv, input logic [31:0] rp,
                       input logic fl, input logic st);
        @(negedge clk);
        rst                = r;
        bus.redirect_valid = rv;
        bus.redirect_pc    = rp;
        bus.flush          = fl;
        bus.stall          = st;
        model_edge(r, rv, rp, fl, st);
        q.push_back(m);
    endtask

    task automatic after_edge();
        @(posedge clk);
        #2;
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (q.size() > 0) begin
                e = q.pop_front();
                chk("imem_addr",   bus.imem_addr,                   e.addr);
                chk("if_id_valid", {31'd0, bus.if_id_valid},         {31'd0, e.vld});
                chk("if_id_pc",    bus.if_id_pc,                     e.ipc);
                chk("if_id_pc4",   bus.if_id_pc_plus4,               e.ipc4);
                chk("if_id_instr", bus.if_id_instr,                  e.instr);
                chk("misaligned",  {31'd0, bus.redirect_misaligned}, {31'd0, e.mis});
                chk("fetch_count", bus.fetch_count,                  e.cnt);
            end
        end
    end

    initial begin : watchdog
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, time %0t required below 2000000", $time);
        $fatal(1, "timeout");
    end

    initial begin : driver
        logic [31:0] cnt_save;
        logic r, rv, fl, st;
        logic [31:0] rp;
        for (int i = 0; i < 64; i++) mem[i] = $urandom;
        mem[0] = 32'h0010_0093;
        mem[1] = 32'h0020_0113;
        mem[2] = 32'h0030_0193;
        mem[3] = 32'h0040_0213;
        mem[8] = 32'h0080_0413;
        rst = 1'b1; bus.redirect_valid = 1'b0; bus.redirect_pc = 32'h0;
        bus.flush = 1'b0; bus.stall = 1'b0;

        // Reset and sequential fetch
        cyc(1, 0, 0, 0, 0);
        cyc(1, 0, 0, 0, 0);
        after_edge();
        chk("rst_valid", {31'd0, bus.if_id_valid}, 32'd0);
        chk("rst_instr", bus.if_id_instr, NOP);
        chk("rst_addr",  bus.imem_addr, 32'h0);
        cyc(0, 0, 0, 0, 0);
        after_edge();
        chk("seq0_pc",    bus.if_id_pc, 32'h0);
        chk("seq0_instr", bus.if_id_instr, 32'h0010_0093);
        cyc(0, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 0);
        after_edge();
        chk("seq2_pc",    bus.if_id_pc, 32'h8);
        chk("seq2_instr", bus.if_id_instr, 32'h0030_0193);

        // Stall holds everything for three cycles
        for (int i = 0; i < 3; i++) cyc(0, 0, 0, 0, 1);
        after_edge();
        chk("stall_pc",    bus.if_id_pc, 32'h8);
        chk("stall_addr",  bus.imem_addr, 32'hC);
        chk("stall_count", bus.fetch_count, 32'd3);
        cyc(0, 0, 0, 0, 0);
        after_edge();
        chk("unstall_pc", bus.if_id_pc, 32'hC);
        chk("seq_count",  bus.fetch_count, 32'd4);

        // Redirect wins over stall
        cyc(0, 1, 32'h20, 0, 1);
        after_edge();
        chk("redir_addr",  bus.imem_addr, 32'h20);
        chk("redir_valid", {31'd0, bus.if_id_valid}, 32'd0);
        chk("redir_instr", bus.if_id_instr, NOP);
        cyc(0, 0, 0, 0, 0);
        after_edge();
        chk("redir_tgt_pc",    bus.if_id_pc, 32'h20);
        chk("redir_tgt_instr", bus.if_id_instr, 32'h0080_0413);

        // Misaligned redirect
        cyc(0, 1, 32'h1E, 0, 0);
        after_edge();
        chk("mis_addr",  bus.imem_addr, 32'h1C);
        chk("mis_pulse", {31'd0, bus.redirect_misaligned}, 32'd1);
        cyc(0, 0, 0, 0, 0);
        after_edge();
        chk("mis_clear", {31'd0, bus.redirect_misaligned}, 32'd0);

        // Flush alone at PC 0x10
        cyc(0, 1, 32'h10, 0, 0);
        cnt_save = m.cnt;
        cyc(0, 0, 0, 1, 0);
        after_edge();
        chk("flush_valid", {31'd0, bus.if_id_valid}, 32'd0);
        chk("flush_addr",  bus.imem_addr, 32'h10);
        cyc(0, 0, 0, 0, 0);
        after_edge();
        chk("flush_refetch_pc", bus.if_id_pc, 32'h10);
        chk("flush_count",      bus.fetch_count, cnt_save + 32'd1);

        // PC wrap, then reset together with a redirect
        cyc(0, 1, 32'hFFFF_FFFC, 0, 0);
        cyc(0, 0, 0, 0, 0);
        after_edge();
        chk("wrap_addr", bus.imem_addr, 32'h0);
        chk("wrap_pc4",  bus.if_id_pc_plus4, 32'h0);
        cyc(1, 1, 32'h40, 0, 0);
        after_edge();
        chk("rst_mid_addr",  bus.imem_addr, 32'h0);
        chk("rst_mid_pc",    bus.if_id_pc, 32'h0);
        chk("rst_mid_count", bus.fetch_count, 32'h0);

        // Randomized control traffic
        for (int i = 0; i < 400; i++) begin
            r  = ($urandom_range(0, 99) < 2);
            rv = ($urandom_range(0, 99) < 10);
            fl = ($urandom_range(0, 99) < 10);
            st = ($urandom_range(0, 99) < 25);
            rp = (($urandom_range(0, 9) == 0) ? 32'hFFFF_FF00 : 32'h0) | {24'd0, 8'($urandom)};
            cyc(r, rv, rp, fl, st);
        end
        cyc(0, 0, 0, 0, 0);
        after_edge();
        after_edge();
        chk("scoreboard_drained", q.size(), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/fetch_stage.md
# fetch_stage

Instruction-fetch stage of the single-issue RV32 pipeline. It owns the program counter, drives the word address into the combinational `instruction_memory`, and registers the returned instruction together with its PC into the IF/ID pipeline register for the decoder. It supports decode-side stalls, pipeline flushes and control-flow redirects from the execute stage.

## Interface
- `RESET_PC`, default 32'h0000_0000: PC value loaded on reset.
- `NOP_INSTR`, default 32'h0000_0013: `addi x0,x0,0`, the instruction loaded into IF/ID for bubbles.
- `clk` in 1: single clock; all state updates on the rising edge.
- `rst` in 1: synchronous, active-high reset.
- `imem_addr` out 32: byte address to instruction memory; always equals the PC register; combinational from the register.
- `imem_instr` in 32: instruction returned combinationally by instruction memory for `imem_addr`.
- `stall` in 1: decode or hazard unit cannot accept a new instruction.
- `flush` in 1: kill the IF/ID contents.
- `redirect_valid` in 1: branch or jump taken; load a new PC.
- `redirect_pc` in 32: redirect target byte address.
- `if_id_valid` out 1: IF/ID holds a real instruction.
- `if_id_pc` out 32: PC of the IF/ID instruction.
- `if_id_pc_plus4` out 32: `if_id_pc + 4`, registered.
- `if_id_instr` out 32: registered instruction.
- `redirect_misaligned` out 1: one-cycle registered pulse; the last accepted redirect had `redirect_pc[1:0] != 0`.
- `fetch_count` out 32: number of instructions written into IF/ID with valid=1 since reset.

## Operation
- State: PC register, IF/ID register (valid, pc, pc_plus4, instr), `redirect_misaligned` flop, `fetch_count` counter.
- Per-edge priority: `rst` > `redirect_valid` > `flush` > `stall` > normal advance.
- **rst**:
  - PC = `RESET_PC`.
  - `if_id_valid` = 0, `if_id_instr` = `NOP_INSTR`, `if_id_pc` = 0, `if_id_pc_plus4` = 0.
  - `redirect_misaligned` = 0, `fetch_count` = 0.
  - Reset asserted mid-operation discards everything, including a simultaneous redirect.
- **redirect_valid=1**:
  - PC = `{redirect_pc[31:2], 2'b00}`.
  - IF/ID becomes a bubble: valid = 0, instr = `NOP_INSTR`, pc/pc_plus4 hold.
  - `redirect_misaligned` = `|redirect_pc[1:0]`.
  - Redirect overrides `stall` and `flush`.
- **flush=1 without redirect**: IF/ID becomes a bubble. The PC holds, so the instruction at the current PC is refetched next cycle.
- **stall=1 alone**: PC and IF/ID hold their values exactly, including valid.
- **Normal advance**:
  - IF/ID = {1, PC, PC+4, `imem_instr`}.
  - PC = PC + 4; wraps mod 2^32, so 0xFFFF_FFFC advances to 0x0000_0000.
  - `fetch_count` increments, wrapping mod 2^32.
- `redirect_misaligned` is 0 in every cycle that does not follow an accepted redirect.
- `fetch_count` increments only on a normal advance; never on a stall, flush or redirect.
- Address range: the memory indexes `addr[7:2]`, so PCs beyond 0xFC alias. The stage does not range-check.

## Timing
- `imem_addr` reflects the new PC in the cycle after the edge that loaded it; zero-cycle path into memory.
- Fetch latency is one cycle: the instruction at PC P appears on `if_id_*` after the edge ending the cycle in which `imem_addr`=P.
- Redirect asserted in cycle N:
  - IF/ID shows a bubble in N+1, with `imem_addr` = target.
  - The target instruction is valid in IF/ID in N+2.
  - Two-cycle penalty counting the killed slot.
- The first valid IF/ID entry after reset deassertion appears one cycle later, with pc=`RESET_PC`.
- All outputs are registered except `imem_addr`, which is a direct PC register output.
- There is no combinational path from `stall`, `flush` or `redirect_*` to any output.

## Test plan
- **Reset/sequential fetch**:
  - Stimulus: memory words 0..3 = 0x00100093, 0x00200113, 0x00300193, 0x00400213; `rst` for 2 cycles, then release.
  - Response: IF/ID shows (pc 0x0, 0x00100093), (0x4, 0x00200113), (0x8, …), (0xC, …) on consecutive cycles; `fetch_count` reaches 4.
- **Stall**:
  - Stimulus: assert `stall` for 3 cycles while IF/ID holds pc 0x8.
  - Response: `if_id_*` and `imem_addr`=0xC stay constant; `fetch_count` is unchanged. The cycle after release, IF/ID has pc 0xC.
- **Redirect vs stall**:
  - Stimulus: `redirect_valid`=1, `redirect_pc`=0x20 and `stall`=1 in the same cycle.
  - Response: next cycle `imem_addr`=0x20 with `if_id_valid`=0 and instr 0x00000013; the cycle after, IF/ID has pc 0x20 with word 8 of memory.
- **Misaligned redirect**:
  - Stimulus: `redirect_pc`=0x1E.
  - Response: `imem_addr`=0x1C; `redirect_misaligned`=1 for exactly one cycle.
- **Flush alone**:
  - Stimulus: `flush`=1 at PC 0x10.
  - Response: IF/ID becomes a bubble; `imem_addr` stays 0x10. Next cycle IF/ID has pc 0x10 and `fetch_count` increments once.
- **Wrap and reset mid-run**:
  - Stimulus: redirect to 0xFFFF_FFFC, advance, then assert `rst` together with `redirect_valid` (target 0x40).
  - Response: PC goes 0xFFFF_FFFC → 0x0; after the reset edge PC=`RESET_PC`, all IF/ID fields are at reset values and `fetch_count`=0.
